// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one combinational CodeROM read port between
// instruction fetch and load/store, with a one-entry response buffer per requester.
module rom_port_arbiter #(
  parameter int unsigned            ADDR_WIDTH = 64,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ROM_SIZE   = 16,
  parameter logic [ADDR_WIDTH-1:0]  ROM_BASE   = '0
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] if_rsp_data_o,
  output logic                  if_rsp_err_o,
  input  logic                  if_rsp_ready_i,
  input  logic                  if_flush_i,

  input  logic                  ld_req_valid_i,
  output logic                  ld_req_ready_o,
  input  logic [ADDR_WIDTH-1:0] ld_addr_i,
  output logic                  ld_rsp_valid_o,
  output logic [DATA_WIDTH-1:0] ld_rsp_data_o,
  output logic                  ld_rsp_err_o,
  input  logic                  ld_rsp_ready_i,

  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_rdata_i,
  input  logic                  rom_illegal_i
);

  typedef enum logic {
    GRANT_IF = 1'b0,
    GRANT_LD = 1'b1
  } grant_e;

  grant_e                  last_grant;
  logic                    if_elig;
  logic                    ld_elig;
  logic                    grant_if;
  logic                    grant_ld;
  logic                    range_err;
  logic                    acc_err;
  logic [DATA_WIDTH-1:0]   cap_data;

  // Eligibility is gated by rst so nothing is accepted while reset is held.
  always_comb begin
    if_elig   = 1'b0;
    ld_elig   = 1'b0;
    grant_if  = 1'b0;
    grant_ld  = 1'b0;
    range_err = 1'b0;
    acc_err   = 1'b0;
    cap_data  = '0;
    rom_addr_o = '0;

    if_elig = !rst && if_req_valid_i && !if_flush_i && (!if_rsp_valid_o || if_rsp_ready_i);
    ld_elig = !rst && ld_req_valid_i && (!ld_rsp_valid_o || ld_rsp_ready_i);

    grant_if = if_elig && (!ld_elig || (last_grant == GRANT_LD));
    grant_ld = ld_elig && (!if_elig || (last_grant == GRANT_IF));

    if (grant_if) begin
      rom_addr_o = if_addr_i;
    end else if (grant_ld) begin
      rom_addr_o = ld_addr_i;
    end

    range_err = rom_addr_o[ADDR_WIDTH-1:ROM_SIZE] != ROM_BASE[ADDR_WIDTH-1:ROM_SIZE];
    acc_err   = rom_illegal_i || range_err || (rom_addr_o[1:0] != 2'b00);
    cap_data  = acc_err ? '0 : rom_rdata_i;
  end

  assign if_req_ready_o = grant_if;
  assign ld_req_ready_o = grant_ld;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= GRANT_LD;
    end else if (grant_if) begin
      last_grant <= GRANT_IF;
    end else if (grant_ld) begin
      last_grant <= GRANT_LD;
    end
  end

  // A flush never coincides with an IF grant, so grant-first ordering is safe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_rsp_valid_o <= 1'b0;
      if_rsp_data_o  <= '0;
      if_rsp_err_o   <= 1'b0;
    end else if (grant_if) begin
      if_rsp_valid_o <= 1'b1;
      if_rsp_data_o  <= cap_data;
      if_rsp_err_o   <= acc_err;
    end else if (if_flush_i || if_rsp_ready_i) begin
      if_rsp_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_rsp_valid_o <= 1'b0;
      ld_rsp_data_o  <= '0;
      ld_rsp_err_o   <= 1'b0;
    end else if (grant_ld) begin
      ld_rsp_valid_o <= 1'b1;
      ld_rsp_data_o  <= cap_data;
      ld_rsp_err_o   <= acc_err;
    end else if (ld_rsp_ready_i) begin
      ld_rsp_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: arbitration order, latency, error flags,
// back-pressure, flush and asynchronous reset.
module tb_rom_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_valid_i;
  logic        if_req_ready_o;
  logic [63:0] if_addr_i;
  logic        if_rsp_valid_o;
  logic [31:0] if_rsp_data_o;
  logic        if_rsp_err_o;
  logic        if_rsp_ready_i;
  logic        if_flush_i;
  logic        ld_req_valid_i;
  logic        ld_req_ready_o;
  logic [63:0] ld_addr_i;
  logic        ld_rsp_valid_o;
  logic [31:0] ld_rsp_data_o;
  logic        ld_rsp_err_o;
  logic        ld_rsp_ready_i;
  logic [63:0] rom_addr_o;
  logic [31:0] rom_rdata_i;
  logic        rom_illegal_i;

  int unsigned n_checks;
  int unsigned n_fails;

  rom_port_arbiter #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (32),
    .ROM_SIZE   (16),
    .ROM_BASE   (64'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_req_valid_i (if_req_valid_i),
    .if_req_ready_o (if_req_ready_o),
    .if_addr_i      (if_addr_i),
    .if_rsp_valid_o (if_rsp_valid_o),
    .if_rsp_data_o  (if_rsp_data_o),
    .if_rsp_err_o   (if_rsp_err_o),
    .if_rsp_ready_i (if_rsp_ready_i),
    .if_flush_i     (if_flush_i),
    .ld_req_valid_i (ld_req_valid_i),
    .ld_req_ready_o (ld_req_ready_o),
    .ld_addr_i      (ld_addr_i),
    .ld_rsp_valid_o (ld_rsp_valid_o),
    .ld_rsp_data_o  (ld_rsp_data_o),
    .ld_rsp_err_o   (ld_rsp_err_o),
    .ld_rsp_ready_i (ld_rsp_ready_i),
    .rom_addr_o     (rom_addr_o),
    .rom_rdata_i    (rom_rdata_i),
    .rom_illegal_i  (rom_illegal_i)
  );

  // ROM contents: word 0 holds a NOP, every other word is a tagged address.
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    if (a == 64'h0) return 32'h0000_0013;
    return 32'hC0DE_0000 ^ a[31:0];
  endfunction

  logic force_illegal;
  assign rom_rdata_i   = rom_word(rom_addr_o);
  assign rom_illegal_i = force_illegal;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_fails        = 0;
    rst            = 1'b0;
    if_req_valid_i = 1'b0;
    if_addr_i      = '0;
    if_rsp_ready_i = 1'b0;
    if_flush_i     = 1'b0;
    ld_req_valid_i = 1'b0;
    ld_addr_i      = '0;
    ld_rsp_ready_i = 1'b0;
    force_illegal  = 1'b0;

    // Reset state, and no acceptance while reset is held
    #2 rst = 1'b1;
    #1;
    check_eq("rst_if_valid", 64'(if_rsp_valid_o), 64'd0);
    check_eq("rst_ld_valid", 64'(ld_rsp_valid_o), 64'd0);
    check_eq("rst_if_data",  64'(if_rsp_data_o),  64'd0);
    check_eq("rst_ld_err",   64'(ld_rsp_err_o),   64'd0);
    check_eq("rst_if_ready_idle", 64'(if_req_ready_o), 64'd0);
    if_req_valid_i = 1'b1;
    #1;
    check_eq("rst_if_ready_held", 64'(if_req_ready_o), 64'd0);
    if_req_valid_i = 1'b0;
    step();
    step();
    rst = 1'b0;

    // IF alone at 0x0
    if_req_valid_i = 1'b1;
    if_addr_i      = 64'h0;
    #1;
    check_eq("t1_if_ready", 64'(if_req_ready_o), 64'd1);
    check_eq("t1_ld_ready", 64'(ld_req_ready_o), 64'd0);
    check_eq("t1_rom_addr", rom_addr_o, 64'h0);
    step();
    if_req_valid_i = 1'b0;
    check_eq("t1_if_rsp_valid", 64'(if_rsp_valid_o), 64'd1);
    check_eq("t1_if_rsp_data",  64'(if_rsp_data_o),  64'h13);
    check_eq("t1_if_rsp_err",   64'(if_rsp_err_o),   64'd0);
    if_rsp_ready_i = 1'b1;
    ld_rsp_ready_i = 1'b1;
    step();
    check_eq("t1_if_popped", 64'(if_rsp_valid_o), 64'd0);

    // Both continuously eligible; IF won last, so LD takes the first tie
    if_req_valid_i = 1'b1;
    if_addr_i      = 64'h4;
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 64'h100;
    for (int i = 0; i < 4; i++) begin
      logic exp_if;
      exp_if = (i % 2) == 1;
      #1;
      check_eq("t2_if_ready", 64'(if_req_ready_o), 64'(exp_if));
      check_eq("t2_ld_ready", 64'(ld_req_ready_o), 64'(!exp_if));
      check_eq("t2_rom_addr", rom_addr_o, exp_if ? 64'h4 : 64'h100);
      step();
      if (exp_if) begin
        check_eq("t2_if_rsp_valid", 64'(if_rsp_valid_o), 64'd1);
        check_eq("t2_if_rsp_data",  64'(if_rsp_data_o),  64'(rom_word(64'h4)));
      end else begin
        check_eq("t2_ld_rsp_valid", 64'(ld_rsp_valid_o), 64'd1);
        check_eq("t2_ld_rsp_data",  64'(ld_rsp_data_o),  64'(rom_word(64'h100)));
      end
    end
    if_req_valid_i = 1'b0;

    // LD error cases: misaligned, out of window, ROM illegal, then a clean read
    ld_addr_i = 64'h102;
    #1;
    check_eq("t3_mis_ready", 64'(ld_req_ready_o), 64'd1);
    step();
    check_eq("t3_mis_err",  64'(ld_rsp_err_o),  64'd1);
    check_eq("t3_mis_data", 64'(ld_rsp_data_o), 64'd0);
    ld_addr_i = 64'h10000;
    step();
    check_eq("t3_range_err",  64'(ld_rsp_err_o),  64'd1);
    check_eq("t3_range_data", 64'(ld_rsp_data_o), 64'd0);
    ld_addr_i     = 64'h200;
    force_illegal = 1'b1;
    step();
    check_eq("t3_illegal_err",  64'(ld_rsp_err_o),  64'd1);
    check_eq("t3_illegal_data", 64'(ld_rsp_data_o), 64'd0);
    force_illegal = 1'b0;
    step();
    check_eq("t3_ok_err",  64'(ld_rsp_err_o),  64'd0);
    check_eq("t3_ok_data", 64'(ld_rsp_data_o), 64'(rom_word(64'h200)));
    ld_req_valid_i = 1'b0;
    step();

    // IF response held: IF blocked, LD gets every cycle, data stays stable
    if_rsp_ready_i = 1'b0;
    if_req_valid_i = 1'b1;
    if_addr_i      = 64'h8;
    step();
    check_eq("t4_if_held_valid", 64'(if_rsp_valid_o), 64'd1);
    if_addr_i      = 64'hC;
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 64'h20;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t4_if_ready_blocked", 64'(if_req_ready_o), 64'd0);
      check_eq("t4_ld_ready",         64'(ld_req_ready_o), 64'd1);
      check_eq("t4_rom_addr",         rom_addr_o, 64'h20);
      step();
      check_eq("t4_if_data_stable", 64'(if_rsp_data_o), 64'(rom_word(64'h8)));
    end
    if_rsp_ready_i = 1'b1;
    #1;
    check_eq("t4_if_ready_pop", 64'(if_req_ready_o), 64'd1);
    check_eq("t4_rom_addr_if",  rom_addr_o, 64'hC);
    step();
    check_eq("t4_if_b2b_valid", 64'(if_rsp_valid_o), 64'd1);
    check_eq("t4_if_b2b_data",  64'(if_rsp_data_o),  64'(rom_word(64'hC)));

    // Flush while IF buffer valid and IF requesting; LD in parallel
    if_rsp_ready_i = 1'b0;
    if_flush_i     = 1'b1;
    if_addr_i      = 64'h10;
    ld_addr_i      = 64'h24;
    #1;
    check_eq("t5_flush_if_ready", 64'(if_req_ready_o), 64'd0);
    check_eq("t5_flush_ld_ready", 64'(ld_req_ready_o), 64'd1);
    step();
    if_flush_i     = 1'b0;
    ld_req_valid_i = 1'b0;
    check_eq("t5_if_flushed",  64'(if_rsp_valid_o), 64'd0);
    check_eq("t5_ld_valid",    64'(ld_rsp_valid_o), 64'd1);
    check_eq("t5_ld_data",     64'(ld_rsp_data_o),  64'(rom_word(64'h24)));
    check_eq("t5_ld_err",      64'(ld_rsp_err_o),   64'd0);
    #1;
    check_eq("t5_if_ready_after", 64'(if_req_ready_o), 64'd1);
    step();
    check_eq("t5_if_data_after", 64'(if_rsp_data_o), 64'(rom_word(64'h10)));

    // Fill both buffers, then assert reset between edges
    if_req_valid_i = 1'b0;
    ld_rsp_ready_i = 1'b0;
    ld_req_valid_i = 1'b1;
    ld_addr_i      = 64'h28;
    step();
    ld_req_valid_i = 1'b0;
    check_eq("t6_if_full", 64'(if_rsp_valid_o), 64'd1);
    check_eq("t6_ld_full", 64'(ld_rsp_valid_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_if_valid_async", 64'(if_rsp_valid_o), 64'd0);
    check_eq("t6_ld_valid_async", 64'(ld_rsp_valid_o), 64'd0);
    if_req_valid_i = 1'b1;
    ld_req_valid_i = 1'b1;
    if_addr_i      = 64'h30;
    ld_addr_i      = 64'h40;
    #1;
    check_eq("t6_if_ready_in_rst", 64'(if_req_ready_o), 64'd0);
    check_eq("t6_ld_ready_in_rst", 64'(ld_req_ready_o), 64'd0);
    step();
    check_eq("t6_ld_valid_in_rst", 64'(ld_rsp_valid_o), 64'd0);
    rst = 1'b0;
    #1;
    check_eq("t6_tie_if_ready", 64'(if_req_ready_o), 64'd1);
    check_eq("t6_tie_ld_ready", 64'(ld_req_ready_o), 64'd0);
    check_eq("t6_tie_rom_addr", rom_addr_o, 64'h30);
    step();
    check_eq("t6_if_rsp_data", 64'(if_rsp_data_o), 64'(rom_word(64'h30)));
    if_req_valid_i = 1'b0;
    ld_req_valid_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
